// File: rtl/cla_alu_pipe_pkg.sv
// cla_alu_pkg: op encoding, flag bit positions and flag width shared by the ALU pipeline
package cla_alu_pkg;
  typedef enum logic [1:0] {OP_ADD = 2'd0, OP_SUB = 2'd1, OP_ADC = 2'd2, OP_SBC = 2'd3} op_e;
  localparam int FLG_V = 4;
  localparam int FLG_C = 3;
  localparam int FLG_N = 2;
  localparam int FLG_Z = 1;
  localparam int FLG_P = 0;
  localparam int FLAGS_W = 5;
endpackage

// File: rtl/cla_alu_pipe_group.sv
// cla_group: G-bit lookahead group producing group propagate/generate and its local sum
module cla_group #(
  parameter int G = 4
) (
  input  logic [G-1:0] a,
  input  logic [G-1:0] b,
  input  logic         cin,
  output logic         pg,
  output logic         gg,
  output logic [G-1:0] sum
);
  logic c;
  always_comb begin
    c = cin;
    pg = 1'b1;
    gg = 1'b0;
    sum = '0;
    for (int j = 0; j < G; j++) begin
      sum[j] = a[j] ^ b[j] ^ c;
      c = (a[j] & b[j]) | ((a[j] ^ b[j]) & c);
      gg = (a[j] & b[j]) | ((a[j] ^ b[j]) & gg);
      pg = pg & (a[j] ^ b[j]);
    end
  end
endmodule

// File: rtl/cla_alu_pipe.sv
// cla_alu_pipe: two-stage CLA add/sub with valid/ready, carry chaining and {V,C,N,Z,P} flags.
// Define CLA_ALU_PIPE_SAT_EN to clamp signed overflow instead of wrapping.
module cla_alu_pipe
  import cla_alu_pkg::*;
#(
  parameter int N = 16,
  parameter int G = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         op,
  input  logic [N-1:0]       a,
  input  logic [N-1:0]       b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N-1:0]       sum,
  output logic [FLAGS_W-1:0] flags
);
  localparam int NG = N / G;
  logic               stall, ld, cin, c, v;
  op_e                op_in, op_q, op_d;
  logic [N-1:0]       b_eff, a_q, a_d, b_q, b_d, p_q, p_d, g_q, g_d, cbit, raw, res;
  logic [NG-1:0]      pg_d, gg_d, pg_q, gg_q;
  logic [NG:0]        gc;
  logic [N-1:0]       grp_sum_unused;
  logic               unused_top_pg;
  logic               s1_valid_q, s1_valid_d, out_valid_q, out_valid_d, c_reg_q, c_reg_d;
  logic [N-1:0]       sum_q, sum_d;
  logic [FLAGS_W-1:0] flags_q, flags_d, flags_new;
  assign stall = out_valid_q & ~out_ready;
  assign in_ready = ~stall;
  assign out_valid = out_valid_q;
  assign sum = sum_q;
  assign flags = flags_q;
  assign op_in = op_e'(op);
  assign b_eff = (op_in == OP_SUB || op_in == OP_SBC) ? ~b : b;
  // Only the group P/G feed stage 2; the group-local sums are recomputed once the carry is known
  for (genvar i = 0; i < NG; i++) begin : g_grp
    cla_group #(.G(G)) u_grp (
      .a(a[i*G +: G]), .b(b_eff[i*G +: G]), .cin(1'b0),
      .pg(pg_d[i]), .gg(gg_d[i]), .sum(grp_sum_unused[i*G +: G])
    );
  end
  assign unused_top_pg = ^{p_q, g_q, grp_sum_unused};
  always_comb begin
    cin = op_q == OP_ADD ? 1'b0 : op_q == OP_SUB ? 1'b1 : c_reg_q;
    gc = '0;
    cbit = '0;
    gc[0] = cin;
    for (int i = 0; i < NG; i++) gc[i+1] = gg_q[i] | (pg_q[i] & gc[i]);
    for (int i = 0; i < NG; i++) begin
      cbit[i*G] = gc[i];
      for (int j = 1; j < G; j++) cbit[i*G+j] = g_q[i*G+j-1] | (p_q[i*G+j-1] & cbit[i*G+j-1]);
    end
    raw = a_q ^ b_q ^ cbit;
    c = gc[NG];
    v = (a_q[N-1] == b_q[N-1]) & (raw[N-1] != a_q[N-1]);
`ifdef CLA_ALU_PIPE_SAT_EN
    res = v ? {a_q[N-1], {(N-1){~a_q[N-1]}}} : raw;
`else
    res = raw;
`endif
    flags_new = '0;
    flags_new[FLG_V] = v;
    flags_new[FLG_C] = c;
    flags_new[FLG_N] = res[N-1];
    flags_new[FLG_Z] = ~|res;
    flags_new[FLG_P] = ~^res;
    ld = ~stall & s1_valid_q;
    s1_valid_d = stall ? s1_valid_q : in_valid;
    op_d = stall ? op_q : op_in;
    a_d = stall ? a_q : a;
    b_d = stall ? b_q : b_eff;
    p_d = stall ? p_q : a ^ b_eff;
    g_d = stall ? g_q : a & b_eff;
    out_valid_d = stall ? out_valid_q : s1_valid_q;
    sum_d = ld ? res : sum_q;
    flags_d = ld ? flags_new : flags_q;
    c_reg_d = ld ? c : c_reg_q;
  end
  always_ff @(posedge clk) begin
    op_q <= op_d;
    a_q <= a_d;
    b_q <= b_d;
    p_q <= p_d;
    g_q <= g_d;
    pg_q <= stall ? pg_q : pg_d;
    gg_q <= stall ? gg_q : gg_d;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      out_valid_q <= 1'b0;
      sum_q <= '0;
      flags_q <= '0;
      c_reg_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      out_valid_q <= out_valid_d;
      sum_q <= sum_d;
      flags_q <= flags_d;
      c_reg_q <= c_reg_d;
    end
  end
endmodule

// File: tb/tb_cla_alu_pipe.sv
// tb_cla_alu_pipe: directed and randomized checks of the pipelined CLA ALU (N=16, G=4)
module tb_cla_alu_pipe;
  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready;
  logic [1:0]  op;
  logic [15:0] a, b;
  logic        in_ready, out_valid;
  logic [15:0] sum;
  logic [4:0]  flags;
  int tests = 0;
  int fails = 0;
`ifdef CLA_ALU_PIPE_SAT_EN
  localparam logic [15:0] OVF_SUM = 16'h7FFF;
  localparam logic [4:0]  OVF_FLG = 5'b10000;
`else
  localparam logic [15:0] OVF_SUM = 16'h8000;
  localparam logic [4:0]  OVF_FLG = 5'b10100;
`endif

  cla_alu_pipe #(.N(16), .G(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    op = 2'd0;
    a = '0;
    b = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic present(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y);
    in_valid = 1'b1;
    op = o;
    a = x;
    b = y;
  endtask

  task automatic test_reset;
    do_reset();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    tests++; if (sum !== 16'h0) begin fails++; $display("FAIL reset_sum got=%h exp=0000", sum); end
    tests++; if (flags !== 5'b0) begin fails++; $display("FAIL reset_flags got=%b exp=00000", flags); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_add_overflow;
    present(2'd0, 16'h7FFF, 16'h0001);
    tick();
    in_valid = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL ovf_early_valid got=%b exp=0", out_valid); end
    tick();
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL ovf_valid got=%b exp=1", out_valid); end
    tests++; if (sum !== OVF_SUM) begin fails++; $display("FAIL ovf_sum got=%h exp=%h", sum, OVF_SUM); end
    tests++; if (flags !== OVF_FLG) begin fails++; $display("FAIL ovf_flags got=%b exp=%b", flags, OVF_FLG); end
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL ovf_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_sub_zero;
    present(2'd1, 16'h0005, 16'h0005);
    tick();
    in_valid = 1'b0;
    tick();
    tests++; if ({out_valid, sum, flags} !== {1'b1, 16'h0000, 5'b01011}) begin fails++; $display("FAIL sub_zero got=%b/%h/%b exp=1/0000/01011", out_valid, sum, flags); end
    tick();
  endtask

  task automatic test_sbc_chain;
    present(2'd1, 16'h0000, 16'h0001);
    tick();
    present(2'd3, 16'h0005, 16'h0001);
    tick();
    in_valid = 1'b0;
    tests++; if ({out_valid, sum, flags} !== {1'b1, 16'hFFFF, 5'b00101}) begin fails++; $display("FAIL sub_borrow got=%b/%h/%b exp=1/ffff/00101", out_valid, sum, flags); end
    tick();
    tests++; if ({out_valid, sum, flags} !== {1'b1, 16'h0003, 5'b01001}) begin fails++; $display("FAIL sbc_borrow got=%b/%h/%b exp=1/0003/01001", out_valid, sum, flags); end
    tick();
  endtask

  task automatic test_back_to_back;
    present(2'd0, 16'hFFFF, 16'h0001);
    tick();
    present(2'd2, 16'h0000, 16'h0000);
    tick();
    in_valid = 1'b0;
    tests++; if ({out_valid, sum, flags} !== {1'b1, 16'h0000, 5'b01011}) begin fails++; $display("FAIL b2b_first got=%b/%h/%b exp=1/0000/01011", out_valid, sum, flags); end
    tick();
    tests++; if ({out_valid, sum, flags} !== {1'b1, 16'h0001, 5'b00000}) begin fails++; $display("FAIL b2b_adc got=%b/%h/%b exp=1/0001/00000", out_valid, sum, flags); end
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_backpressure;
    present(2'd0, 16'h0001, 16'h0001);
    tick();
    present(2'd0, 16'h0002, 16'h0002);
    tick();
    present(2'd0, 16'h0003, 16'h0003);
    out_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", i, in_ready); end
      tests++; if ({out_valid, sum, flags} !== {1'b1, 16'h0002, 5'b00000}) begin fails++; $display("FAIL bp_hold[%0d] got=%b/%h/%b exp=1/0002/00000", i, out_valid, sum, flags); end
      tick();
    end
    out_ready = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    tests++; if ({out_valid, sum, flags} !== {1'b1, 16'h0004, 5'b00000}) begin fails++; $display("FAIL bp_second got=%b/%h/%b exp=1/0004/00000", out_valid, sum, flags); end
    tick();
    tests++; if ({out_valid, sum, flags} !== {1'b1, 16'h0006, 5'b00001}) begin fails++; $display("FAIL bp_third got=%b/%h/%b exp=1/0006/00001", out_valid, sum, flags); end
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_midflight;
    present(2'd0, 16'hFFFF, 16'h0001);
    tick();
    present(2'd0, 16'hFFFF, 16'h0001);
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++; if ({out_valid, sum, flags} !== {1'b0, 16'h0000, 5'b00000}) begin fails++; $display("FAIL mid_reset got=%b/%h/%b exp=0/0000/00000", out_valid, sum, flags); end
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_reset_ghost got=%b exp=0", out_valid); end
    present(2'd2, 16'h0001, 16'h0001);
    tick();
    in_valid = 1'b0;
    tick();
    tests++; if ({out_valid, sum, flags} !== {1'b1, 16'h0002, 5'b00000}) begin fails++; $display("FAIL mid_reset_adc got=%b/%h/%b exp=1/0002/00000", out_valid, sum, flags); end
    tick();
  endtask

  task automatic test_random;
    logic [20:0] q[$];
    logic [20:0] exp_v;
    logic [16:0] full;
    logic [15:0] eb, r;
    logic        mc, cin, c, v;
    do_reset();
    mc = 1'b0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      in_valid = $urandom_range(0, 3) != 0;
      op = 2'($urandom);
      a = ($urandom_range(0, 5) == 0) ? 16'hFFFF : 16'($urandom);
      b = ($urandom_range(0, 5) == 0) ? 16'h8000 : 16'($urandom);
      out_ready = $urandom_range(0, 3) != 0;
      #1;
      if (out_valid && out_ready) begin
        tests++;
        if (q.size() == 0) begin
          fails++; $display("FAIL rand_extra got=%h/%b exp=no output", sum, flags);
        end else begin
          exp_v = q.pop_front();
          if ({sum, flags} !== exp_v) begin fails++; $display("FAIL rand_result cyc=%0d got=%h/%b exp=%h/%b", cyc, sum, flags, exp_v[20:5], exp_v[4:0]); end
        end
      end
      if (in_valid && in_ready) begin
        eb = op[0] ? ~b : b;
        cin = op == 2'd0 ? 1'b0 : op == 2'd1 ? 1'b1 : mc;
        full = {1'b0, a} + {1'b0, eb} + {16'd0, cin};
        r = full[15:0];
        c = full[16];
        v = (a[15] == eb[15]) && (r[15] != a[15]);
`ifdef CLA_ALU_PIPE_SAT_EN
        if (v) r = a[15] ? 16'h8000 : 16'h7FFF;
`endif
        mc = c;
        q.push_back({r, v, c, r[15], r == 16'h0, ~^r});
      end
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (out_valid) begin
        tests++;
        if (q.size() == 0) begin
          fails++; $display("FAIL drain_extra got=%h/%b exp=no output", sum, flags);
        end else begin
          exp_v = q.pop_front();
          if ({sum, flags} !== exp_v) begin fails++; $display("FAIL drain_result got=%h/%b exp=%h/%b", sum, flags, exp_v[20:5], exp_v[4:0]); end
        end
      end
      tick();
    end
    tests++; if (q.size() != 0) begin fails++; $display("FAIL rand_pending got=%0d exp=0", q.size()); end
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_sub_zero();
    test_sbc_chain();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
